// File: rtl/move_timer_pkg.sv
// Shared definitions for the move timer: drainer state encoding, default
// counter width and drop-counter width.
package move_timer_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int DROP_W    = 8;

    // Drainer sequencing toward the printer handshake.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a queued result
        ST_ISSUE   = 2'd1,  // tx_start pulse
        ST_WAIT_HI = 2'd2,  // waiting for printer to raise busy
        ST_WAIT_LO = 2'd3   // waiting for printer to finish
    } drain_state_t;

endpackage

// File: rtl/meas_fifo.sv
// Synchronous result FIFO, DEPTH x W, with simultaneous push/pop.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   head             oldest entry, valid when !empty
//   full, empty      occupancy flags
//   level            number of stored entries
module meas_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes the write when a read frees a slot this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/move_timer.sv
// Cycle stopwatch feeding the hex/RS232 time printer. Measures cycles from
// meas_start to meas_stop, queues results, and hands them one at a time to
// the printer via its start/busy handshake.
// Ports:
//   clk, RST     clock, asynchronous active-low reset
//   meas_start   pulse: begin/restart a measurement
//   meas_stop    pulse: end the running measurement (push result)
//   tx_busy      printer busy
//   tx_start     one-cycle pulse to printer start
//   time_cnt     value for the printer, held until the next pop
//   running      measurement in progress
//   q_level      queued results
//   drop_cnt     results lost to a full queue (saturating)
module move_timer
    import move_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   meas_start,
    input  logic                   meas_stop,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [CNT_W-1:0]       time_cnt,
    output logic                   running,
    output logic [$clog2(DEPTH):0] q_level,
    output logic [DROP_W-1:0]      drop_cnt
);
    logic [CNT_W-1:0] cnt, head;
    logic             stop_ok, pop, full, empty, drop;
    drain_state_t     state, state_nxt;

    assign stop_ok = meas_stop && running;
    assign pop     = (state == ST_IDLE) && !empty;
    assign drop    = stop_ok && full && !pop;

    // Counter reads 1 the cycle after start, so at a stop N cycles after
    // start it holds N. A start coincident with a stop still pushes cnt
    // (the FIFO samples it this edge) before the restart reloads it.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (meas_start) begin
            cnt     <= CNT_W'(1);
            running <= 1'b1;
        end else if (stop_ok) begin
            running <= 1'b0;
        end else if (running && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    meas_fifo #(.W(CNT_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (RST),
        .push      (stop_ok),
        .push_data (cnt),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (q_level)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            time_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop) time_cnt <= head;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            ST_IDLE:    if (!empty) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (tx_busy)  state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!tx_busy) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/move_timer.md
# move_timer

Cycle-accurate stopwatch that sits directly upstream of the hex-over-RS232 time printer. It measures the clock cycles between a measure-start and a measure-stop event, for example AI move search begin and end. Each result goes into a small queue, and results are handed one at a time to the printer through its `start`/`busy` handshake, so back-to-back measurements are not lost while the UART is busy.

## Interface
Parameters:
- `CNT_W`, 32, width of the cycle count; must match printer `time_cnt`.
- `DEPTH`, 4, result queue entries; power of two, ≥ 2.

Ports:
- `clk`  input  1  single system clock, rising edge.
- `RST`  input  1  reset, asynchronous, active-low (0 = reset).
- `meas_start`  input  1  one-cycle pulse; begins (or restarts) a measurement.
- `meas_stop`  input  1  one-cycle pulse; ends the running measurement.
- `tx_busy`  input  1  printer `busy`.
- `tx_start`  output  1  one-cycle pulse to printer `start`.
- `time_cnt`  output  CNT_W  value presented to the printer; valid on the `tx_start` cycle and held until the next pop.
- `running`  output  1  measurement in progress.
- `q_level`  output  $clog2(DEPTH)+1  entries currently queued.
- `drop_cnt`  output  8  results discarded because the queue was full; saturates at 255.

## Operation
- Reset value of every output is 0. Counter, queue pointers and drainer state are also cleared.
- Measurement rules:
  - If `meas_start` is seen at cycle t0 and `meas_stop` at cycle t0+N (N ≥ 1), the pushed value is N.
  - The count saturates at 2^CNT_W−1 and never wraps.
- `meas_stop` while not running is ignored.
- `meas_start` while running discards the current measurement and restarts from t0 = this cycle.
- `meas_start` and `meas_stop` in the same cycle while running: push the current result, then restart. While idle, only start takes effect.
- Queue push happens on a valid stop.
  - If the queue is full, the value is dropped and `drop_cnt` is incremented.
  - Push and pop in the same cycle are both performed; level is unchanged. A full queue accepts the push if a pop occurs in the same cycle.
- Drainer FSM states:
  - IDLE: when the queue is non-empty, latch the head into `time_cnt`, pop, and go to ISSUE.
  - ISSUE: assert `tx_start` for exactly 1 cycle, then go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy`=1 (the printer raises busy the cycle after start), then go to WAIT_LO.
  - WAIT_LO: wait for `tx_busy`=0, then go to IDLE.
- Reset mid-operation clears everything immediately. A partially printed value is abandoned and is not re-sent.

## Timing
- A stop at cycle s makes `q_level` increment visible at s+1.
- Empty queue, drainer IDLE, push at s:
  - pop/latch at s+1;
  - `tx_start` high during s+2;
  - `time_cnt` stable from s+2 onward.
- The minimum spacing between `tx_start` pulses is 4 cycles; in practice it is set by printer completion.
- `tx_start` is never asserted while in WAIT_HI or WAIT_LO.
- `running` goes high the cycle after `meas_start` and low the cycle after a stop.

## Structure
- Shared package `move_timer_pkg`:
  - drainer state encoding (IDLE, ISSUE, WAIT_HI, WAIT_LO, 2-bit);
  - default `CNT_W`;
  - `DROP_W` = 8.
- One sub-module, `meas_fifo`:
  - synchronous FIFO of `DEPTH` × `CNT_W`;
  - outputs: head data, full, empty, level;
  - supports simultaneous push/pop;
  - asynchronous active-low reset.
- The stopwatch counter and the drainer FSM live in `move_timer`.

## Test plan
- Single measurement:
  - stimulus: start at cycle 10, stop at cycle 110, model printer raises busy 1 cycle after start and holds it 50 cycles;
  - response: one `tx_start` with `time_cnt`=100, queue empty afterward.
- Back-to-back measurements:
  - stimulus: three measurements of 5, 7 and 9 cycles while the printer holds busy for 200 cycles;
  - response: pulses in order 5, 7, 9, each issued only after the previous busy falls.
- Overflow drop:
  - stimulus: DEPTH=4, six measurements while the printer is stalled busy;
  - response: `q_level` peaks at 4 (the first result is popped immediately, so 5 are retained in total), `drop_cnt`=1.
- Restart and simultaneous events:
  - stimulus: start@0, start@20 (restart), stop@50;
  - response: value 30 pushed.
  - stimulus: start and stop together while running;
  - response: push of the current result and `running` stays 1.
- Saturation:
  - stimulus: CNT_W=8, stop 300 cycles after start;
  - response: pushed value 255.
- Reset mid-print:
  - stimulus: assert `RST`=0 asynchronously while in WAIT_LO with 2 entries queued;
  - response: all outputs 0 immediately, no `tx_start` after release until a new stop.
